// File: rtl/nexys_starship_pkg.sv
// Shared definitions for the starship monster controller.
// Holds the lane index constants, the per-lane state encoding, the
// default gameplay timing values and a small popcount helper used by
// the damage and kill counters.
package nexys_starship_pkg;

    // Lane indices, matching the shoot_dir encoding
    localparam int LANE_TOP   = 0;
    localparam int LANE_BTM   = 1;
    localparam int LANE_LEFT  = 2;
    localparam int LANE_RIGHT = 3;
    localparam int NUM_LANES  = 4;

    // Per-lane lifecycle state
    typedef enum logic [1:0] {
        LS_IDLE     = 2'b00,
        LS_ACTIVE   = 2'b01,
        LS_COOLDOWN = 2'b10
    } lane_state_e;

    // Default gameplay timing, in ticks / hit counts
    localparam int DEF_MONSTER_LIFE = 8;
    localparam int DEF_COOLDOWN     = 4;
    localparam int DEF_MAX_DAMAGE   = 5;

    // Number of set bits in a 4-bit lane vector
    function automatic logic [2:0] popcount4(input logic [3:0] vec);
        popcount4 = {2'b00, vec[0]} + {2'b00, vec[1]}
                  + {2'b00, vec[2]} + {2'b00, vec[3]};
    endfunction

endpackage

// File: rtl/nexys_starship_lane.sv
// Single monster lane: IDLE -> ACTIVE (countdown) -> COOLDOWN -> IDLE.
// Ports:
//   Clk, Reset   clock and synchronous active-high reset
//   tick         game-time enable; timers move only on tick
//   spawn_en     spawning globally allowed (game active, not over)
//   spawn_flag   spawn request for this lane, honoured only on tick
//   shot_here    a valid shot aimed at this lane this cycle
//   present      registered, high while the lane is ACTIVE
//   timer        registered remaining ticks, 0 unless ACTIVE
//   kill, hit    registered one-cycle pulses for shot / expired monster
module nexys_starship_lane
    import nexys_starship_pkg::*;
#(
    parameter int MONSTER_LIFE = DEF_MONSTER_LIFE,
    parameter int COOLDOWN     = DEF_COOLDOWN
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       tick,
    input  logic       spawn_en,
    input  logic       spawn_flag,
    input  logic       shot_here,
    output logic       present,
    output logic [3:0] timer,
    output logic       kill,
    output logic       hit
);

    localparam logic [3:0] LIFE_C = 4'(MONSTER_LIFE);
    localparam logic [3:0] CD_C   = 4'(COOLDOWN);

    lane_state_e state_r;
    lane_state_e state_nxt_s;
    logic [3:0]  timer_r;
    logic [3:0]  timer_nxt_s;
    logic        kill_nxt_s;
    logic        hit_nxt_s;
    logic        present_r;
    logic [3:0]  timer_out_r;
    logic        kill_r;
    logic        hit_r;

    // Next-state and pulse decode for the lane lifecycle
    always_comb begin
        state_nxt_s = state_r;
        timer_nxt_s = timer_r;
        kill_nxt_s  = 1'b0;
        hit_nxt_s   = 1'b0;
        case (state_r)
            LS_IDLE: begin
                // Shots at an idle lane are ignored here; the top flags the miss
                if (tick && spawn_flag && spawn_en) begin
                    state_nxt_s = LS_ACTIVE;
                    timer_nxt_s = LIFE_C;
                end else begin
                    timer_nxt_s = 4'd0;
                end
            end
            LS_ACTIVE: begin
                // Checking the shot first makes a kill win over a same-cycle expiry
                if (shot_here) begin
                    state_nxt_s = LS_COOLDOWN;
                    timer_nxt_s = CD_C;
                    kill_nxt_s  = 1'b1;
                end else if (tick) begin
                    if (timer_r <= 4'd1) begin
                        state_nxt_s = LS_COOLDOWN;
                        timer_nxt_s = CD_C;
                        hit_nxt_s   = 1'b1;
                    end else begin
                        timer_nxt_s = timer_r - 4'd1;
                    end
                end else begin
                    timer_nxt_s = timer_r;
                end
            end
            LS_COOLDOWN: begin
                if (tick) begin
                    if (timer_r <= 4'd1) begin
                        state_nxt_s = LS_IDLE;
                        timer_nxt_s = 4'd0;
                    end else begin
                        timer_nxt_s = timer_r - 4'd1;
                    end
                end else begin
                    timer_nxt_s = timer_r;
                end
            end
            default: begin
                state_nxt_s = LS_IDLE;
                timer_nxt_s = 4'd0;
            end
        endcase
    end

    // State, timer and registered output update
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_r     <= LS_IDLE;
            timer_r     <= 4'd0;
            present_r   <= 1'b0;
            timer_out_r <= 4'd0;
            kill_r      <= 1'b0;
            hit_r       <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            timer_r     <= timer_nxt_s;
            present_r   <= (state_nxt_s == LS_ACTIVE);
            timer_out_r <= (state_nxt_s == LS_ACTIVE) ? timer_nxt_s : 4'd0;
            kill_r      <= kill_nxt_s;
            hit_r       <= hit_nxt_s;
        end
    end

    assign present = present_r;
    assign timer   = timer_out_r;
    assign kill    = kill_r;
    assign hit     = hit_r;

endmodule

// File: rtl/nexys_starship_monster_ctrl.sv
// Monster controller: four independent lanes fed by the PRNG spawn flags,
// plus shot decode, miss detection, saturating damage / kill counters and
// a sticky game_over flag.
// Ports:
//   Clk, Reset                 clock and synchronous active-high reset
//   tick, game_active          game-time enable and spawn permission
//   top/btm/left/right_random  spawn requests for lanes 0..3
//   shoot_valid, shoot_dir     one-cycle shot strobe and target lane
//   monster_present, lane_timer  per-lane ACTIVE flag and remaining ticks
//   kill_pulse, hit_pulse, miss_pulse  one-cycle event pulses
//   damage, kill_count, game_over      saturating counters and end flag
module nexys_starship_monster_ctrl
    import nexys_starship_pkg::*;
#(
    parameter int MONSTER_LIFE = DEF_MONSTER_LIFE,
    parameter int COOLDOWN     = DEF_COOLDOWN,
    parameter int MAX_DAMAGE   = DEF_MAX_DAMAGE
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        tick,
    input  logic        game_active,
    input  logic        top_random,
    input  logic        btm_random,
    input  logic        left_random,
    input  logic        right_random,
    input  logic        shoot_valid,
    input  logic [1:0]  shoot_dir,
    output logic [3:0]  monster_present,
    output logic [15:0] lane_timer,
    output logic [3:0]  kill_pulse,
    output logic [3:0]  hit_pulse,
    output logic        miss_pulse,
    output logic [3:0]  damage,
    output logic [7:0]  kill_count,
    output logic        game_over
);

    localparam logic [3:0] MAX_C = 4'(MAX_DAMAGE);

    logic [3:0]  spawn_s;
    logic [3:0]  shot_s;
    logic [3:0]  present_s;
    logic [15:0] timer_s;
    logic [3:0]  kill_s;
    logic [3:0]  hit_s;
    logic        spawn_en_s;
    logic [4:0]  damage_sum_s;
    logic [3:0]  damage_nxt_s;
    logic [8:0]  kill_sum_s;
    logic [7:0]  kill_nxt_s;
    logic        miss_nxt_s;
    logic        game_over_nxt_s;
    logic [3:0]  damage_r;
    logic [7:0]  kill_count_r;
    logic        miss_r;
    logic        game_over_r;

    assign spawn_s[LANE_TOP]   = top_random;
    assign spawn_s[LANE_BTM]   = btm_random;
    assign spawn_s[LANE_LEFT]  = left_random;
    assign spawn_s[LANE_RIGHT] = right_random;

    assign spawn_en_s = game_active & ~game_over_r;

    for (genvar n = 0; n < NUM_LANES; n++) begin : g_lane
        assign shot_s[n] = shoot_valid && (shoot_dir == 2'(n));

        nexys_starship_lane #(
            .MONSTER_LIFE (MONSTER_LIFE),
            .COOLDOWN     (COOLDOWN)
        ) u_lane (
            .Clk        (Clk),
            .Reset      (Reset),
            .tick       (tick),
            .spawn_en   (spawn_en_s),
            .spawn_flag (spawn_s[n]),
            .shot_here  (shot_s[n]),
            .present    (present_s[n]),
            .timer      (timer_s[4*n +: 4]),
            .kill       (kill_s[n]),
            .hit        (hit_s[n])
        );
    end

    // Counter updates from the lane pulses and miss / game-over decode
    always_comb begin
        damage_sum_s    = {1'b0, damage_r} + {2'b00, popcount4(hit_s)};
        damage_nxt_s    = (damage_sum_s > 5'd15) ? 4'd15 : damage_sum_s[3:0];
        kill_sum_s      = {1'b0, kill_count_r} + {6'b000000, popcount4(kill_s)};
        kill_nxt_s      = (kill_sum_s > 9'd255) ? 8'd255 : kill_sum_s[7:0];
        // present_s reflects the lane state seen by this shot, so a shot
        // that coincides with a spawn into an idle lane is still a miss
        miss_nxt_s      = shoot_valid & ~present_s[shoot_dir];
        game_over_nxt_s = game_over_r | (damage_r >= MAX_C);
    end

    // Counter, miss and game-over registers
    always_ff @(posedge Clk) begin
        if (Reset) begin
            damage_r     <= 4'd0;
            kill_count_r <= 8'd0;
            miss_r       <= 1'b0;
            game_over_r  <= 1'b0;
        end else begin
            damage_r     <= damage_nxt_s;
            kill_count_r <= kill_nxt_s;
            miss_r       <= miss_nxt_s;
            game_over_r  <= game_over_nxt_s;
        end
    end

    assign monster_present = present_s;
    assign lane_timer      = timer_s;
    assign kill_pulse      = kill_s;
    assign hit_pulse       = hit_s;
    assign miss_pulse      = miss_r;
    assign damage          = damage_r;
    assign kill_count      = kill_count_r;
    assign game_over       = game_over_r;

endmodule

// File: doc/nexys_starship_monster_ctrl.md
Name: nexys_starship_monster_ctrl

Overview:
Consumes the per-direction spawn flags from nexys_starship_PRNG (top_random, btm_random, left_random, right_random) and runs one monster lifecycle per direction: spawn, countdown, kill-or-hit, cooldown. It tracks the player's damage and kills and asserts game_over. Outputs feed the display/VGA and scoring logic.

Parameters:
MONSTER_LIFE, 8, ticks a spawned monster survives before it hits the ship (range 2..15)
COOLDOWN, 4, ticks a lane stays blocked after a kill or a hit (range 1..15)
MAX_DAMAGE, 5, damage count that ends the game (range 1..15)

Ports:
Clk  in  1  system clock
Reset  in  1  synchronous, active-high reset
tick  in  1  single-cycle game-time enable; all timers advance only on tick
game_active  in  1  when low, no new spawns (existing lanes keep running)
top_random  in  1  spawn request, lane 0
btm_random  in  1  spawn request, lane 1
left_random  in  1  spawn request, lane 2
right_random  in  1  spawn request, lane 3
shoot_valid  in  1  one-cycle shot strobe
shoot_dir  in  2  shot lane: 0 top, 1 btm, 2 left, 3 right
monster_present  out  4  bit n high while lane n is ACTIVE
lane_timer  out  16  {lane3,lane2,lane1,lane0}, each 4 bits: remaining ticks (0 when not ACTIVE)
kill_pulse  out  4  one-cycle pulse, lane n monster shot
hit_pulse  out  4  one-cycle pulse, lane n monster expired
miss_pulse  out  1  one-cycle pulse, shot at a lane that is not ACTIVE
damage  out  4  saturating hit count
kill_count  out  8  saturating kill count
game_over  out  1  sticky, high once damage >= MAX_DAMAGE

Behaviour:
- Clock and reset: one clock (Clk). Reset is synchronous and active-high. In the Reset cycle every lane goes to IDLE with timer 0 and every output is 0. Reset overrides all other inputs, including in the middle of a countdown.
- Per-lane FSM. States are IDLE, ACTIVE and COOLDOWN, with a 4-bit timer. All transitions are registered; outputs are registered and update in the cycle after the causing edge.
  - IDLE -> ACTIVE when tick & spawn_flag & game_active & !game_over. Timer loads MONSTER_LIFE.
  - ACTIVE, shoot_valid & shoot_dir==lane: -> COOLDOWN, timer=COOLDOWN, kill_pulse[lane]. A shot does not need tick.
  - ACTIVE, tick & timer==1 with no matching shot: -> COOLDOWN, timer=COOLDOWN, hit_pulse[lane].
  - ACTIVE, tick & timer>1: timer decrements.
  - If a kill and an expiry happen in the same cycle, the kill wins and no hit is recorded.
  - COOLDOWN, tick & timer==1: -> IDLE, timer 0. On tick with timer>1, timer decrements. Spawn flags are ignored in COOLDOWN.
  - A spawn flag is sampled only on tick. Flags on non-tick cycles are discarded, never queued.
- Shots:
  - shoot_valid with the target lane not ACTIVE: miss_pulse for one cycle, no state change.
  - Shots while game_over still resolve kills and misses.
- Damage and kills:
  - damage increases by the popcount of the hit_pulse vector generated that cycle, saturating at 15.
  - kill_count increments by the popcount of kills, saturating at 255. At most one kill is possible per cycle.
- game_over:
  - Set in the cycle after the damage register first reaches >= MAX_DAMAGE. Cleared only by Reset.
  - While game_over is high, lanes in ACTIVE and COOLDOWN continue to completion but no new spawns occur.
  - Further hits still update damage, saturating.
- Simultaneous events:
  - Hits on several lanes in one cycle are all counted.
  - A spawn in lane n and a shot at lane n in the same cycle while lane n is IDLE: the shot is a miss, and the lane becomes ACTIVE next cycle.

Decomposition:
- Shared package nexys_starship_pkg holds:
  - Lane index constants: LANE_TOP=0, LANE_BTM=1, LANE_LEFT=2, LANE_RIGHT=3.
  - Lane state encoding: IDLE=2'b00, ACTIVE=2'b01, COOLDOWN=2'b10.
  - Defaults for MONSTER_LIFE, COOLDOWN and MAX_DAMAGE.
- Sub-module nexys_starship_lane: the single-lane FSM plus timer, instantiated four times.
  - Inputs: Clk, Reset, tick, spawn_en, spawn_flag, shot_here.
  - Outputs: present, timer, kill, hit.
- The top level contains only the shot decode, the popcount/saturation counters and the game_over flag.

Test Plan:
1. Reset mid-countdown: lane 0 ACTIVE with timer 5, assert Reset for one cycle -> next cycle monster_present=0, lane_timer=0, damage=0, kill_count=0, game_over=0.
2. Expiry: top_random=1 on one tick with game_active=1, then 8 more ticks with no shots -> monster_present[0] high for exactly 8 ticks, hit_pulse=4'b0001 once, damage=1, lane_timer[3:0] counts 8..1. After 4 further ticks the lane returns to IDLE.
3. Kill vs. expiry race: lane 2 at timer 1, tick and shoot_valid with shoot_dir=2 in the same cycle -> kill_pulse=4'b0100, hit_pulse=0, kill_count +1, damage unchanged.
4. Multi-hit and game_over: damage=3 and lanes 1 and 3 expire on the same tick -> damage=5 the next cycle, game_over=1 one cycle later. A later tick with all four spawn flags high produces no spawns.
5. Miss and non-tick spawn: shoot_dir=1 with lane 1 IDLE -> miss_pulse=1. left_random=1 on a cycle with tick=0 -> lane 2 stays IDLE.
6. Saturation: force 260 kills on alternating lanes -> kill_count holds at 255. Sixteen or more hits -> damage holds at 15.
